// File: rtl/mem_port_arbiter_if.sv
// Signal bundle shared by the memory port arbiter, the IF/ME pipeline
// stages and the single-ported memory macro.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch stage
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_flush;
  logic [DW-1:0]   if_rdata;
  logic            if_valid;
  // Memory stage
  logic            me_req;
  logic            me_we;
  logic [AW-1:0]   me_addr;
  logic [DW-1:0]   me_wdata;
  logic [DW/8-1:0] me_wstrb;
  logic [DW-1:0]   me_rdata;
  logic            me_valid;
  // Memory macro
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  // Arbiter view: takes stage requests and memory responses, drives the rest.
  modport master (
    input  if_req, if_addr, if_flush,
    input  me_req, me_we, me_addr, me_wdata, me_wstrb,
    input  mem_rdata, mem_ack,
    output if_rdata, if_valid, me_rdata, me_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Environment view: the two stages plus the memory macro.
  modport slave (
    output if_req, if_addr, if_flush,
    output me_req, me_we, me_addr, me_wdata, me_wstrb,
    output mem_rdata, mem_ack,
    input  if_rdata, if_valid, me_rdata, me_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and the
// memory stage (ME). ME has fixed priority, but after MAX_STREAK consecutive
// ME grants with IF waiting, IF wins the next arbitration. One access is in
// flight at a time; the winner gets a one-cycle VALID pulse when it leaves
// the response state. A branch flush during an IF access discards its data.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  mem_port_arbiter_if.master io_bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_BUSY,
    S_ME_BUSY,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_grant_me;
  logic            w_grant_if;
  logic            w_ack_take;

  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW/8-1:0] r_mem_wstrb;
  logic [DW-1:0]   r_if_rdata;
  logic            r_if_valid;
  logic [DW-1:0]   r_me_rdata;
  logic            r_me_valid;
  logic [3:0]      r_streak;
  logic            r_drop;
  logic            r_owner_me;

  // Next-state and grant decision; requests only matter in IDLE, ack only while busy.
  always_comb begin
    w_state_next = r_state;
    w_grant_me   = 1'b0;
    w_grant_if   = 1'b0;
    w_ack_take   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.me_req && (!io_bus.if_req || (r_streak < STREAK_MAX))) begin
          w_grant_me   = 1'b1;
          w_state_next = S_ME_BUSY;
        end else if (io_bus.if_req) begin
          w_grant_if   = 1'b1;
          w_state_next = S_IF_BUSY;
        end
      end
      S_IF_BUSY, S_ME_BUSY: begin
        if (io_bus.mem_ack) begin
          w_ack_take   = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Memory request registers, starvation streak and flush bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_streak    <= '0;
      r_drop      <= 1'b0;
      r_owner_me  <= 1'b0;
    end else begin
      if (w_grant_me) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= io_bus.me_we;
        r_mem_addr  <= io_bus.me_addr;
        r_mem_wdata <= io_bus.me_wdata;
        r_mem_wstrb <= io_bus.me_wstrb;
        r_owner_me  <= 1'b1;
        // Only grants that make IF wait count towards the streak.
        if (io_bus.if_req)
          r_streak <= (r_streak >= STREAK_MAX) ? STREAK_MAX : r_streak + 4'd1;
        else
          r_streak <= '0;
      end else if (w_grant_if) begin
        // Fetches are always reads; wdata is irrelevant and left as is.
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= io_bus.if_addr;
        r_mem_wstrb <= '0;
        r_owner_me  <= 1'b0;
        r_streak    <= '0;
      end
      if (w_ack_take)
        r_mem_req <= 1'b0;
      if ((r_state == S_IF_BUSY) && io_bus.if_flush)
        r_drop <= 1'b1;
      else if (r_state == S_RESP)
        r_drop <= 1'b0;
    end
  end

  // Response registers: read data captured on ack, VALID pulsed when leaving RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_rdata <= '0;
      r_if_valid <= 1'b0;
      r_me_rdata <= '0;
      r_me_valid <= 1'b0;
    end else begin
      r_if_valid <= (r_state == S_RESP) && !r_owner_me && !r_drop;
      r_me_valid <= (r_state == S_RESP) && r_owner_me;
      // A flush coincident with the ack already counts as a drop.
      if ((r_state == S_IF_BUSY) && io_bus.mem_ack && !(r_drop || io_bus.if_flush))
        r_if_rdata <= io_bus.mem_rdata;
      if ((r_state == S_ME_BUSY) && io_bus.mem_ack)
        r_me_rdata <= io_bus.mem_rdata;
    end
  end

  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.mem_wstrb = r_mem_wstrb;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.if_valid  = r_if_valid;
  assign io_bus.me_rdata  = r_me_rdata;
  assign io_bus.me_valid  = r_me_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. The bench plays both pipeline stages and
// the memory. A transaction-level model predicts, from edge numbers alone,
// when each grant happens, which stage wins, when the ack lands and on which
// edge VALID must appear. Directed cases come first, then a random soak.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_STREAK = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;   // index of the rising edge just passed

  // Stimulus knobs
  int if_pct = 0, me_pct = 0, wait_min = 0, wait_max = 0;
  int flush_pct = 0, spur_pct = 0, rst_pm = 0, flush_mode = 0;
  int force_ack_edge = -1;
  bit fix_rdata_en = 1'b0;
  logic [31:0] fix_rdata = '0;

  // Requester state
  bit          if_pend = 1'b0, me_pend = 1'b0;
  logic [31:0] if_addr_q = '0, me_addr_q = '0, me_wdata_q = '0;
  logic        me_we_q = 1'b0;
  logic [3:0]  me_wstrb_q = '0;

  // Reference model state
  bit          m_busy = 1'b0, m_own_me = 1'b0, m_drop = 1'b0, m_we = 1'b0;
  int          m_grant_edge = -1, m_ack_edge = -1, m_next_sample = 0, m_streak = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  int          m_valid_edge = -1;
  bit          m_valid_me = 1'b0, m_valid_drop = 1'b0, m_valid_we = 1'b0;
  logic [31:0] m_valid_addr = '0;
  logic [31:0] exp_if_rdata = '0, exp_me_rdata = '0;
  bit          seq[$];   // observed VALID order: 1 = ME, 0 = IF

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic apply_inputs();
    bus.if_req   = if_pend;
    bus.if_addr  = if_addr_q;
    bus.me_req   = me_pend;
    bus.me_we    = me_we_q;
    bus.me_addr  = me_addr_q;
    bus.me_wdata = me_wdata_q;
    bus.me_wstrb = me_wstrb_q;
  endtask

  task automatic new_if_req();
    if_pend   = 1'b1;
    if_addr_q = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_me_req();
    me_pend    = 1'b1;
    me_we_q    = 1'($urandom_range(1));
    me_addr_q  = $urandom & 32'hFFFF_FFFC;
    me_wdata_q = $urandom;
    me_wstrb_q = 4'($urandom_range(15));
  endtask

  // Update the model for edge k using the inputs that were present at it,
  // then compare every DUT output against the prediction.
  task automatic model_and_check();
    if (rst) begin
      m_busy = 1'b0; m_streak = 0; m_drop = 1'b0;
      exp_if_rdata = '0; exp_me_rdata = '0;
      m_next_sample = k + 1; m_valid_edge = -1;
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_wstrb", bus.mem_wstrb, 0);
      check("rst_me_rdata", bus.me_rdata, 0);
    end else begin
      if (m_busy && !m_own_me && bus.if_flush) m_drop = 1'b1;
      if (m_busy && k == m_ack_edge) begin
        if (m_own_me) begin
          if (!m_we) exp_me_rdata = bus.mem_rdata;
        end else if (!m_drop) begin
          exp_if_rdata = bus.mem_rdata;
        end
        m_busy = 1'b0;
        m_valid_edge = k + 1; m_valid_me = m_own_me; m_valid_drop = m_drop;
        m_valid_we = m_we; m_valid_addr = m_addr;
        m_next_sample = k + 2;
      end else if (!m_busy && k >= m_next_sample) begin
        if (bus.me_req && (!bus.if_req || m_streak < MAX_STREAK)) begin
          m_own_me = 1'b1; m_we = bus.me_we; m_addr = bus.me_addr;
          m_wdata = bus.me_wdata; m_wstrb = bus.me_wstrb;
          m_streak = bus.if_req ? ((m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK) : 0;
          m_busy = 1'b1;
        end else if (bus.if_req) begin
          m_own_me = 1'b0; m_we = 1'b0; m_addr = bus.if_addr; m_wstrb = '0;
          m_streak = 0;
          m_busy = 1'b1;
        end
        if (m_busy) begin
          m_grant_edge = k;
          m_ack_edge = k + 1 + int'($urandom_range(wait_max, wait_min));
          m_drop = 1'b0;
        end
      end
    end

    check("mem_req", bus.mem_req, m_busy);
    if (m_busy) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_we", bus.mem_we, m_we);
      check("mem_wstrb", bus.mem_wstrb, m_wstrb);
      if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    check("if_valid", bus.if_valid, (k == m_valid_edge) && !m_valid_me && !m_valid_drop);
    check("me_valid", bus.me_valid, (k == m_valid_edge) && m_valid_me);
    check("if_rdata", bus.if_rdata, exp_if_rdata);
    if (k == m_valid_edge && m_valid_me && !m_valid_we)
      check("me_rdata", bus.me_rdata, exp_me_rdata);

    if (bus.if_valid) seq.push_back(1'b0);
    if (bus.me_valid) seq.push_back(1'b1);

    if (k == m_valid_edge) begin
      if (m_valid_me)
        $display("[edge %0d] ME %s addr=0x%08h data=0x%08h", k, m_valid_we ? "store" : "load ",
                 m_valid_addr, m_valid_we ? m_wdata : exp_me_rdata);
      else if (m_valid_drop)
        $display("[edge %0d] IF fetch addr=0x%08h discarded by flush", k, m_valid_addr);
      else
        $display("[edge %0d] IF fetch addr=0x%08h data=0x%08h", k, m_valid_addr, exp_if_rdata);
    end
  endtask

  // Stage and memory behaviour for the next edge.
  task automatic drive_next();
    bit rst_next;
    if (k == m_valid_edge) begin
      if (m_valid_me) me_pend = 1'b0;
      else            if_pend = 1'b0;
    end
    if (!if_pend && int'($urandom_range(99)) < if_pct) new_if_req();
    if (!me_pend && int'($urandom_range(99)) < me_pct) new_me_req();
    rst_next = int'($urandom_range(999)) < rst_pm;
    if (rst_next) begin
      if_pend = 1'b0;
      me_pend = 1'b0;
    end
    rst = rst_next;
    bus.mem_ack = (m_busy && (k + 1 == m_ack_edge)) ||
                  (!m_busy && int'($urandom_range(99)) < spur_pct) ||
                  (k + 1 == force_ack_edge);
    bus.mem_rdata = fix_rdata_en ? fix_rdata : $urandom;
    bus.if_flush = (int'($urandom_range(99)) < flush_pct) ||
                   (m_busy && !m_own_me &&
                    ((flush_mode == 1 && k + 1 == m_grant_edge + 1) ||
                     (flush_mode == 2 && k + 1 == m_ack_edge)));
    apply_inputs();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    k++;
    model_and_check();
    drive_next();
  endtask

  task automatic run_until_valid(input int max_cycles, output int edge_seen);
    bit timed_out;
    int n;
    timed_out = 1'b1;
    edge_seen = -1;
    n = 0;
    while (timed_out && n < max_cycles) begin
      cycle();
      n++;
      if (bus.if_valid || bus.me_valid) begin
        timed_out = 1'b0;
        edge_seen = k;
      end
    end
    check("valid_within_bound", timed_out, 0);
  endtask

  task automatic flush_case(input int mode);
    logic [31:0] prev;
    int cnt, edge_seen;
    prev = exp_if_rdata;
    flush_mode = mode; wait_min = 2; wait_max = 2;
    new_if_req();
    apply_inputs();
    cnt = 0;
    repeat (8) begin
      cycle();
      if (bus.if_valid) cnt++;
    end
    check($sformatf("flush%0d_if_valid_pulses", mode), cnt, 0);
    check($sformatf("flush%0d_if_rdata", mode), bus.if_rdata, prev);
    flush_mode = 0; wait_min = 0; wait_max = 0;
    new_me_req();
    apply_inputs();
    run_until_valid(10, edge_seen);
    check($sformatf("flush%0d_me_served", mode), bus.me_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_edge, edge_seen;
    rst = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.if_flush = 1'b0;
    apply_inputs();
    rst_pm = 0;
    cycle();                       // reset edge
    rst = 1'b1; apply_inputs();
    cycle();                       // second reset edge; drive_next released it

    // Single fetch: VALID is seen by the requester 3 edges after the grant edge.
    fix_rdata_en = 1'b1; fix_rdata = 32'hDEAD_BEEF;
    if_pend = 1'b1; if_addr_q = 32'h0000_0100; apply_inputs();
    req_edge = k + 1;
    run_until_valid(10, edge_seen);
    check("fetch_latency", edge_seen + 1 - req_edge, 3);
    check("fetch_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    fix_rdata_en = 1'b0;

    // Store with four wait cycles on the ack.
    wait_min = 4; wait_max = 4;
    me_pend = 1'b1; me_we_q = 1'b1; me_addr_q = 32'h0000_0400;
    me_wdata_q = 32'h1234_5678; me_wstrb_q = 4'b0011; apply_inputs();
    req_edge = k + 1;
    run_until_valid(15, edge_seen);
    check("store_latency", edge_seen + 1 - req_edge, 7);
    check("store_valid_owner", bus.me_valid, 1);

    // Contention: both stages keep requesting, immediate acks.
    wait_min = 0; wait_max = 0; if_pct = 100; me_pct = 100;
    new_if_req(); new_me_req(); apply_inputs();
    seq.delete();
    for (int i = 0; i < 100 && seq.size() < 12; i++) cycle();
    check("grant_count", seq.size() >= 12, 1);
    for (int i = 0; i < 12 && i < seq.size(); i++)
      check($sformatf("grant_order[%0d]", i), seq[i], (i == 4 || i == 9) ? 0 : 1);
    if_pct = 0; me_pct = 0;
    repeat (20) cycle();

    // Flush during IF_BUSY, then flush coincident with the ack.
    flush_case(1);
    flush_case(2);

    // Reset in the middle of an ME access, then a late ack, then a fetch.
    wait_min = 6; wait_max = 6;
    new_me_req(); me_we_q = 1'b0; apply_inputs();
    repeat (3) cycle();
    check("pre_rst_mem_req", bus.mem_req, 1);
    me_pend = 1'b0; rst = 1'b1; apply_inputs();
    force_ack_edge = k + 2;
    cycle();
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_me_valid", bus.me_valid, 0);
    cycle();                       // stray ack arrives in IDLE
    check("late_ack_mem_req", bus.mem_req, 0);
    force_ack_edge = -1;
    wait_min = 1; wait_max = 1;
    new_if_req(); apply_inputs();
    req_edge = k + 1;
    run_until_valid(10, edge_seen);
    check("post_rst_fetch_latency", edge_seen + 1 - req_edge, 4);
    check("post_rst_if_valid", bus.if_valid, 1);

    // Random soak.
    if_pct = 40; me_pct = 40; wait_min = 0; wait_max = 3;
    flush_pct = 15; spur_pct = 20; rst_pm = 5;
    repeat (3000) cycle();
    if_pct = 0; me_pct = 0; flush_pct = 0; spur_pct = 0; rst_pm = 0;
    repeat (30) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the pipeline's instruction-fetch (IF) and memory (ME) stages. It sits between the CPU's IF/ME stage logic and the memory macro. It grants one access at a time, holds it until the memory acknowledges, and returns data to the winning stage with a one-cycle valid pulse. ME has fixed priority, with a starvation guard for IF, and a branch flush can discard an in-flight fetch.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_STREAK, 4, consecutive ME grants allowed while IF waits (1..15)

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- IF_REQ  in  1  fetch request, held until IF_VALID
- IF_ADDR  in  AW  fetch address
- IF_FLUSH  in  1  discard outstanding fetch (branch taken)
- IF_RDATA  out  DW  fetched word
- IF_VALID  out  1  one-cycle pulse: IF_RDATA valid
- ME_REQ  in  1  data request, held until ME_VALID
- ME_WE  in  1  1 = store, 0 = load
- ME_ADDR  in  AW  data address
- ME_WDATA  in  DW  store data
- ME_WSTRB  in  DW/8  byte enables for stores
- ME_RDATA  out  DW  load data (undefined for stores)
- ME_VALID  out  1  one-cycle pulse: access complete
- MEM_REQ  out  1  memory request, held until MEM_ACK
- MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB  out  1/AW/DW/DW/8  registered copy of granted request
- MEM_RDATA  in  DW  memory read data, valid with MEM_ACK
- MEM_ACK  in  1  memory completes current access this cycle

## Operation
- FSM states: IDLE, IF_BUSY, ME_BUSY, RESP.
- IDLE: sample requests.
  - If ME_REQ and (!IF_REQ or streak < MAX_STREAK): grant ME and go to ME_BUSY.
  - Else if IF_REQ: grant IF and go to IF_BUSY.
  - Else stay in IDLE.
- On a grant, the FSM latches the winner's address, WE, WDATA and WSTRB into the MEM_* registers and sets MEM_REQ=1. IF grants force MEM_WE=0 and MEM_WSTRB=0.
- Streak counter:
  - Increments on an ME grant when IF_REQ was also high.
  - Clears on an IF grant, and on an ME grant when IF_REQ was low.
  - Saturates at MAX_STREAK.
- IF_BUSY / ME_BUSY: hold MEM_REQ and the MEM_* outputs stable. When MEM_ACK=1:
  - Capture MEM_RDATA into IF_RDATA or ME_RDATA.
  - Drop MEM_REQ.
  - Go to RESP, with the owner's VALID set for the next cycle.
- IF_FLUSH:
  - Sampled while IF_BUSY, or in the IF_BUSY→RESP transition cycle: sets a `drop` flag. The access still completes on memory, but IF_VALID is suppressed in RESP and IF_RDATA is left unchanged.
  - In IDLE or ME_BUSY: IF_FLUSH has no effect.
- RESP: exactly one VALID pulse (or none, if dropped). Requests are ignored in this state. Clear `drop`, return to IDLE.
- Requesters must deassert REQ in the cycle they see VALID, or present their next request. The arbiter never samples REQ in RESP, so no double grant is possible.
- RST (any state, including mid-access):
  - Next state IDLE.
  - MEM_REQ=0, IF_VALID=0, ME_VALID=0.
  - streak=0, drop=0.
  - MEM_* address/data, IF_RDATA and ME_RDATA reset to 0.
  - An abandoned memory access is not retried. The memory must tolerate MEM_REQ dropping before MEM_ACK.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- REQ sampled high in IDLE at edge t:
  - MEM_REQ is high after edge t.
  - The earliest MEM_ACK is seen at edge t+1.
  - VALID is high for the cycle after edge t+2.
- Minimum access latency is 3 cycles. Minimum back-to-back spacing is one grant per 3 cycles. Each wait cycle on MEM_ACK adds 1 cycle.
- MEM_ACK is ignored in IDLE and RESP.
- Simultaneous IF_REQ and ME_REQ in IDLE go to ME unless streak == MAX_STREAK, in which case IF wins.
- IF_FLUSH in the same cycle as MEM_ACK for an IF access still suppresses IF_VALID.
- With MAX_STREAK=4 and both stages continuously requesting, the grant sequence is ME,ME,ME,ME,IF,ME,ME,ME,ME,IF,…

## Test plan
- Reset then single fetch:
  - Stimulus: IF_REQ=1 with IF_ADDR=0x100; memory acks 1 cycle after MEM_REQ rises with 0xDEADBEEF.
  - Required: MEM_ADDR=0x100, MEM_WE=0; IF_VALID pulses once, 3 cycles after the request was sampled; IF_RDATA=0xDEADBEEF.
- Store with wait states:
  - Stimulus: ME_REQ, ME_WE=1, ME_ADDR=0x400, ME_WDATA=0x12345678, ME_WSTRB=0b0011; MEM_ACK delayed 4 cycles.
  - Required: MEM_* stable for all 5 request cycles; ME_VALID pulses once, 7 cycles after the request was sampled.
- Contention and starvation guard:
  - Stimulus: IF_REQ and ME_REQ held high for 12 grants, ack always immediate.
  - Required: grant order ME×4, IF, ME×4, IF, ME, ME; no VALID ever pulses for the wrong requester.
- Flush:
  - Stimulus: IF access in progress; IF_FLUSH pulsed during IF_BUSY, and in a second case coincident with MEM_ACK.
  - Required: in both cases, IF_VALID stays 0 and IF_RDATA is unchanged; the following ME request is granted normally.
- Reset mid-access:
  - Stimulus: RST asserted during ME_BUSY with MEM_REQ=1.
  - Required: after the edge, MEM_REQ=0, ME_VALID=0 and the FSM is in IDLE; a late MEM_ACK is ignored; a new IF_REQ is served normally.
